// File: rtl/threshold_pkg.sv
// Shared key codes and controller state encoding for the threshold entry path.
package threshold_pkg;

    localparam logic [3:0] KEY_SEL_LO = 4'hA;
    localparam logic [3:0] KEY_SEL_HI = 4'hB;
    localparam logic [3:0] KEY_BKSP   = 4'hC;
    localparam logic [3:0] KEY_ENTER  = 4'hD;
    localparam logic [3:0] KEY_CANCEL = 4'hE;
    localparam logic [3:0] KEY_NONE   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_to_bin.sv
// Combinational packed-BCD to binary converter (Horner form, most-significant digit first).
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int VAL_W  = 10
) (
    input  logic [4*DIGITS-1:0] bcd_i,
    output logic [VAL_W-1:0]    bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            bin_o = VAL_W'(bin_o * VAL_W'(10)) + VAL_W'(bcd_i[4*i +: 4]);
        end
    end

endmodule

// File: rtl/threshold_entry_ctrl.sv
// Keypad-driven entry, range check and commit of the low/high water alarm thresholds.
//   state    | meaning
//   ST_IDLE  | waiting for A/B; last entry held for the display
//   ST_ENTRY | collecting digits, backspace/cancel/enter, inactivity timer running
//   ST_CHECK | one cycle: range-check the entry against the opposite threshold
module threshold_entry_ctrl
    import threshold_pkg::*;
#(
    parameter int DIGITS      = 3,
    parameter int VAL_W       = 10,
    parameter int TIMEOUT_CYC = 50000000,
    parameter int LOW_DEF     = 100,
    parameter int HIGH_DEF    = 800
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          key,
    input  logic                key_valid,
    output logic [VAL_W-1:0]    thr_low,
    output logic [VAL_W-1:0]    thr_high,
    output logic                editing,
    output logic                entry_target,
    output logic [4*DIGITS-1:0] entry_bcd,
    output logic [1:0]          entry_cnt,
    output logic                done,
    err,
    output logic                timeout
);

    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // Expiry fires on the edge where the idle count would reach TIMEOUT_CYC-1.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 2);

    state_t              state_q, state_d;
    logic                target_q, target_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [VAL_W-1:0]    thr_lo_q, thr_lo_d;
    logic [VAL_W-1:0]    thr_hi_q, thr_hi_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                tmo_pls_q, tmo_pls_d;
    logic                res_q, res_d;
    logic                res_acc_q, res_acc_d;
    logic                res_tgt_q, res_tgt_d;
    logic [VAL_W-1:0]    res_val_q, res_val_d;
    logic [VAL_W-1:0]    value;

    bcd_to_bin #(
        .DIGITS (DIGITS),
        .VAL_W  (VAL_W)
    ) u_bcd_to_bin (
        .bcd_i (bcd_q),
        .bin_o (value)
    );

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        tmo_d     = '0;
        thr_lo_d  = thr_lo_q;
        thr_hi_d  = thr_hi_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tmo_pls_d = 1'b0;
        res_d     = 1'b0;
        res_acc_d = res_acc_q;
        res_tgt_d = res_tgt_q;
        res_val_d = res_val_q;

        // The check verdict is applied one cycle after CHECK so commit and pulses land together.
        if (res_q) begin
            if (res_acc_q) begin
                if (res_tgt_q) thr_hi_d = res_val_q;
                else           thr_lo_d = res_val_q;
                done_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (key_valid && (key == KEY_SEL_LO || key == KEY_SEL_HI)) begin
                    state_d  = ST_ENTRY;
                    target_d = (key == KEY_SEL_HI);
                    bcd_d    = '0;
                    cnt_d    = '0;
                end
            end
            ST_ENTRY: begin
                if (key_valid) begin
                    if (is_digit(key)) begin
                        if (cnt_q < 2'(DIGITS)) begin
                            bcd_d = {bcd_q[4*DIGITS-5:0], key};
                            cnt_d = cnt_q + 2'd1;
                        end
                    end else begin
                        case (key)
                            KEY_BKSP: begin
                                if (cnt_q != 2'd0) begin
                                    bcd_d = {4'h0, bcd_q[4*DIGITS-1:4]};
                                    cnt_d = cnt_q - 2'd1;
                                end
                            end
                            KEY_SEL_LO, KEY_SEL_HI: begin
                                target_d = (key == KEY_SEL_HI);
                                bcd_d    = '0;
                                cnt_d    = '0;
                            end
                            KEY_ENTER: begin
                                if (cnt_q == 2'd0) err_d   = 1'b1;
                                else               state_d = ST_CHECK;
                            end
                            KEY_CANCEL: state_d = ST_IDLE;
                            default: ;
                        endcase
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = ST_IDLE;
                    tmo_pls_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_CHECK: begin
                res_d     = 1'b1;
                res_tgt_d = target_q;
                res_val_d = value;
                res_acc_d = target_q ? (value > thr_lo_q) : (value < thr_hi_q);
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            target_q  <= 1'b0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            thr_lo_q  <= VAL_W'(LOW_DEF);
            thr_hi_q  <= VAL_W'(HIGH_DEF);
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_pls_q <= 1'b0;
            res_q     <= 1'b0;
            res_acc_q <= 1'b0;
            res_tgt_q <= 1'b0;
            res_val_q <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            thr_lo_q  <= thr_lo_d;
            thr_hi_q  <= thr_hi_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tmo_pls_q <= tmo_pls_d;
            res_q     <= res_d;
            res_acc_q <= res_acc_d;
            res_tgt_q <= res_tgt_d;
            res_val_q <= res_val_d;
        end
    end

    assign thr_low      = thr_lo_q;
    assign thr_high     = thr_hi_q;
    assign editing      = (state_q != ST_IDLE) || res_q;
    assign entry_target = target_q;
    assign entry_bcd    = bcd_q;
    assign entry_cnt    = cnt_q;
    assign done         = done_q;
    assign err          = err_q;
    assign timeout      = tmo_pls_q;

endmodule
